// File: rtl/serial_add_sequencer.sv
// Sequencer wrapped around an external 1-bit serial full adder: it takes a parallel operand
// pair, feeds the adder one bit per clock LSB-first, and returns the assembled parallel sum.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             ser_en,
    output logic             ser_first,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_cin,
    input  logic             ser_sum,
    input  logic             ser_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cin_reg;
    logic             cy_out_reg;
    logic             out_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_reg       <= '0;
            cin_reg       <= 1'b0;
            cy_out_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        cin_reg   <= cy_in;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Sum bits enter at the MSB so bit 0 lands at the bottom after WIDTH shifts.
                    sum_reg  <= {ser_sum, sum_reg[WIDTH-1:1]};
                    a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        cy_out_reg    <= ser_cout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state; rst gates in_ready so it rises on release.
    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign ser_en    = (state_reg == ST_SHIFT);
    assign ser_first = ser_en && (cnt_reg == '0);
    assign ser_a     = ser_en && a_sh_reg[0];
    assign ser_b     = ser_en && b_sh_reg[0];
    assign ser_cin   = cin_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cy_out    = cy_out_reg;

endmodule
